// File: rtl/io_ctrl_db.sv
// io_ctrl_db: synchronized, debounced switch/button inputs with sticky press events and a multi-mode LED driver
module io_ctrl_db #(
  parameter int N_SW      = 8,
  parameter int N_BTN     = 8,
  parameter int N_LED     = 8,
  parameter int DB_CYCLES = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SW-1:0]  SW,
  input  logic [N_BTN-1:0] BUTTON,
  input  logic [N_LED-1:0] WReg_LED,
  input  logic [1:0]       WReg_Mode,
  input  logic [7:0]       WReg_Duty,
  input  logic [N_BTN-1:0] Event_Clr,
  output logic [N_SW-1:0]  RReg_Switch,
  output logic [N_BTN-1:0] RReg_Button,
  output logic [N_BTN-1:0] RReg_Event,
  output logic [N_LED-1:0] LED,
  output logic             irq
);
  localparam int NT = N_SW + N_BTN;
  localparam int CW = DB_CYCLES > 1 ? $clog2(DB_CYCLES) : 1;
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic [NT-1:0]    s1_q, s2_q, db_q;
  logic [CW-1:0]    cnt_q [NT];
  logic [N_BTN-1:0] prev_q, ev_q, ev_d;
  logic [BW-1:0]    bc_q;
  logic             ph_q;
  logic [7:0]       pwm_q;
  logic [N_LED-1:0] led_q, led_d, mir;
  // Switches and buttons share one synchronizer/debouncer vector: buttons sit above switches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      db_q <= '0;
      for (int i = 0; i < NT; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= {BUTTON, SW};
      s2_q <= s1_q;
      for (int i = 0; i < NT; i++) begin
        if (s2_q[i] == db_q[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
          db_q[i]  <= s2_q[i];
          cnt_q[i] <= '0;
        end else cnt_q[i] <= cnt_q[i] + CW'(1);
      end
    end
  end
  assign RReg_Switch = db_q[N_SW-1:0];
  assign RReg_Button = db_q[NT-1:N_SW];
  // A debounced rising edge sets the event; set wins over a coincident clear
  always_comb ev_d = (ev_q & ~Event_Clr) | (RReg_Button & ~prev_q);
  // Event flags and the previous debounced button level used for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      ev_q   <= '0;
    end else begin
      prev_q <= RReg_Button;
      ev_q   <= ev_d;
    end
  end
  assign RReg_Event = ev_q;
  assign irq        = |ev_q;
  // Blink divider and PWM counter free-run in every mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bc_q  <= '0;
      ph_q  <= 1'b0;
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_q + 8'd1;
      if (bc_q == BW'(BLINK_DIV - 1)) begin
        bc_q <= '0;
        ph_q <= ~ph_q;
      end else bc_q <= bc_q + BW'(1);
    end
  end
  for (genvar g = 0; g < N_LED; g++) begin : g_mir
    if (g < N_SW) begin : g_sw
      assign mir[g] = db_q[g];
    end else begin : g_pad
      assign mir[g] = 1'b0;
    end
  end
  // LED source selection by mode
  always_comb
    led_d = WReg_Mode == 2'b00 ? WReg_LED :
            WReg_Mode == 2'b01 ? (ph_q ? WReg_LED : '0) :
            WReg_Mode == 2'b10 ? mir :
            (pwm_q < WReg_Duty ? WReg_LED : '0);
  // Registered LED drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_q <= '0;
    else        led_q <= led_d;
  end
  assign LED = led_q;
endmodule

// File: tb/tb_io_ctrl_db.sv
// tb_io_ctrl_db: directed self-checking bench for io_ctrl_db with short debounce and blink periods
module tb_io_ctrl_db;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sw, button, wled, duty, ev_clr;
  logic [1:0] mode;
  logic [7:0] rsw, rbtn, rev, led;
  logic       irq;
  int n_chk = 0;
  int n_fail = 0;

  io_ctrl_db #(.N_SW(8), .N_BTN(8), .N_LED(8), .DB_CYCLES(4), .BLINK_DIV(3)) dut (
    .clk(clk), .rst_n(rst_n), .SW(sw), .BUTTON(button), .WReg_LED(wled),
    .WReg_Mode(mode), .WReg_Duty(duty), .Event_Clr(ev_clr),
    .RReg_Switch(rsw), .RReg_Button(rbtn), .RReg_Event(rev), .LED(led), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int on_cnt, bad_cnt;
    logic found;
    logic [7:0] prev_led, v, other;
    rst_n = 1'b1; sw = '0; button = '0; wled = '0; duty = '0; ev_clr = '0; mode = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_switch", rsw, 0);
    chk("rst_button", rbtn, 0);
    chk("rst_event", rev, 0);
    chk("rst_led", led, 0);
    chk("rst_irq", irq, 0);
    ticks(2);
    rst_n = 1'b1;
    ticks(3);

    // Button 0 press: debounced after exactly 6 clocks, event one clock later
    button[0] = 1'b1;
    ticks(5);
    chk("btn0_not_yet", rbtn[0], 0);
    tick();
    chk("btn0_debounced", rbtn[0], 1);
    chk("btn0_event_not_yet", rev[0], 0);
    tick();
    chk("btn0_event", rev[0], 1);
    chk("btn0_irq", irq, 1);

    // 3-clock glitch on button 1 is rejected
    button[1] = 1'b1;
    ticks(3);
    button[1] = 1'b0;
    ticks(10);
    chk("glitch_button", rbtn[1], 0);
    chk("glitch_event", rev[1], 0);

    // Write-one-to-clear
    ev_clr[0] = 1'b1;
    tick();
    ev_clr[0] = 1'b0;
    chk("clr_event", rev, 0);
    chk("clr_irq", irq, 0);

    // Release: falling edge raises no event
    button[0] = 1'b0;
    ticks(8);
    chk("release_button", rbtn[0], 0);
    chk("release_no_event", rev, 0);

    // Clear coincident with a new rising edge keeps the bit set
    button[0] = 1'b1;
    ticks(6);
    chk("repress_button", rbtn[0], 1);
    ev_clr[0] = 1'b1;
    tick();
    ev_clr[0] = 1'b0;
    chk("set_beats_clear", rev[0], 1);
    ev_clr = 8'hFF;
    tick();
    ev_clr = '0;
    chk("clear_again", rev, 0);

    // Direct mode
    wled = 8'h96;
    tick();
    chk("direct_led", led, 8'h96);

    // Blink mode: 3 clocks A5, 3 clocks 00
    wled = 8'hA5;
    mode = 2'b01;
    tick();
    prev_led = led;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (led !== prev_led) found = 1'b1;
      else prev_led = led;
    end
    chk("blink_toggle_seen", found, 1);
    v = led;
    other = (v == 8'hA5) ? 8'h00 : 8'hA5;
    chk("blink_value_legal", (v == 8'hA5) || (v == 8'h00), 1);
    for (int j = 1; j < 12; j++) begin
      tick();
      chk($sformatf("blink_j%0d", j), led, ((j / 3) % 2 == 0) ? v : other);
    end

    // PWM duty 64
    mode = 2'b11; wled = 8'hFF; duty = 8'd64;
    ticks(2);
    on_cnt = 0; bad_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (led == 8'hFF) on_cnt++;
      else if (led != 8'h00) bad_cnt++;
    end
    chk("pwm64_on", on_cnt, 64);
    chk("pwm64_legal", bad_cnt, 0);

    // PWM duty 0 and 255
    duty = 8'd0;
    ticks(2);
    on_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (led != 8'h00) on_cnt++;
    end
    chk("pwm0_off", on_cnt, 0);
    duty = 8'd255;
    ticks(2);
    on_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (led == 8'hFF) on_cnt++;
    end
    chk("pwm255_on", on_cnt, 255);

    // Pending event and button level before a reset
    mode = 2'b00; wled = 8'hFF;
    button = 8'h04;
    ticks(8);
    chk("pre_rst_event", rev, 8'h04);
    chk("pre_rst_led", led, 8'hFF);

    // Asynchronous reset mid-debounce between clock edges
    sw = 8'h3C;
    ticks(3);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_switch", rsw, 0);
    chk("async_rst_button", rbtn, 0);
    chk("async_rst_event", rev, 0);
    chk("async_rst_led", led, 0);
    chk("async_rst_irq", irq, 0);
    ticks(2);
    rst_n = 1'b1;
    ticks(5);
    chk("post_rst_sw_not_yet", rsw, 0);
    chk("post_rst_no_event", rev, 0);
    tick();
    chk("post_rst_switch", rsw, 8'h3C);
    chk("post_rst_button", rbtn, 8'h04);
    chk("post_rst_no_event2", rev, 0);
    tick();
    chk("held_btn_one_event", rev, 8'h04);
    chk("held_btn_irq", irq, 1);
    ev_clr = 8'h04;
    tick();
    ev_clr = '0;
    ticks(8);
    chk("held_btn_no_repeat", rev, 0);

    // Mirror mode shows debounced switches
    mode = 2'b10;
    tick();
    chk("mirror_led", led, 8'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/io_ctrl_db.md
IO_CTRL_DB -- requirements
Module: io_ctrl_db

Interface
REQ-001 SHALL have parameter N_SW, default 8, switch input count (1..32).
REQ-002 SHALL have parameter N_BTN, default 8, button input count (1..32).
REQ-003 SHALL have parameter N_LED, default 8, LED output count (1..32).
REQ-004 SHALL have parameter DB_CYCLES, default 100000, debounce stability length in clocks (>=1).
REQ-005 SHALL have parameter BLINK_DIV, default 25000000, clocks per blink half-period (>=1).
REQ-006 SHALL use one clock and an asynchronous, active-low reset.
REQ-007 SHALL have port clk  input  1  system clock, all flops rising-edge.
REQ-008 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-009 SHALL have port SW  input  N_SW  raw asynchronous switch levels.
REQ-010 SHALL have port BUTTON  input  N_BTN  raw asynchronous button levels, 1 = pressed.
REQ-011 SHALL have port WReg_LED  input  N_LED  software LED pattern.
REQ-012 SHALL have port WReg_Mode  input  2  LED mode: 00 direct, 01 blink, 10 mirror, 11 PWM.
REQ-013 SHALL have port WReg_Duty  input  8  PWM duty, 0..255.
REQ-014 SHALL have port Event_Clr  input  N_BTN  one-cycle write-one-to-clear strobe for event bits.
REQ-015 SHALL have port RReg_Switch  output  N_SW  debounced switch levels.
REQ-016 SHALL have port RReg_Button  output  N_BTN  debounced button levels.
REQ-017 SHALL have port RReg_Event  output  N_BTN  sticky press-event flags.
REQ-018 SHALL have port LED  output  N_LED  registered LED drive.
REQ-019 SHALL have port irq  output  1  OR of all RReg_Event bits.

Function
REQ-020 SHALL pass every SW and BUTTON bit through a 2-flop synchronizer before any other use.
REQ-021 SHALL keep a per-bit debounce counter: cleared when synchronized value equals stable value, else incremented; when counter equals DB_CYCLES-1 and values differ, the stable value SHALL take the synchronized value and the counter SHALL clear.
REQ-022 SHALL update a debounced output exactly DB_CYCLES+2 clocks after a raw input change held constant; any reversion before that SHALL leave the output unchanged and restart counting.
REQ-023 SHALL set RReg_Event[i] in the cycle after RReg_Button[i] rises 0->1; falling edges SHALL NOT set events.
REQ-024 SHALL clear RReg_Event[i] on the clock following Event_Clr[i]=1; simultaneous set and clear on the same bit SHALL leave the bit set.
REQ-025 SHALL drive irq combinationally from the RReg_Event register: irq = OR of all bits.
REQ-026 SHALL register LED, so a WReg_Mode, WReg_LED or WReg_Duty change appears on LED one clock later.
REQ-027 Mode 00 SHALL drive LED = WReg_LED.
REQ-028 Mode 01 SHALL drive LED = WReg_LED when blink_phase=1, else all zeros; blink_phase SHALL toggle when the blink counter reaches BLINK_DIV-1, the counter then wrapping to 0.
REQ-029 Mode 10 SHALL drive LED from RReg_Switch, low bits aligned, zero-padded if N_SW<N_LED, truncated if N_SW>N_LED.
REQ-030 Mode 11 SHALL drive LED = WReg_LED when free-running 8-bit pwm_cnt < WReg_Duty, else zeros; pwm_cnt wraps 255->0; duty 0 SHALL give LED always 0, duty 255 SHALL give 255 of 256 cycles on.
REQ-031 Blink counter, blink_phase and pwm_cnt SHALL run continuously regardless of mode.

Reset
REQ-032 SHALL, while rst_n=0, clear synchronizers, debounce counters, stable values, RReg_Switch, RReg_Button, RReg_Event, LED, blink counter, blink_phase and pwm_cnt to 0, immediately and independent of clk.
REQ-033 SHALL treat a reset mid-debounce as a full restart; no event SHALL be generated by reset release, even if BUTTON is held high (the held button SHALL produce exactly one event once debounced).

Verification (DB_CYCLES=4, BLINK_DIV=3)
REQ-034 SHALL check: BUTTON[0] 0->1 held -> RReg_Button[0]=1 exactly 6 clocks later, RReg_Event[0]=1 and irq=1 one clock after that.
REQ-035 SHALL check: BUTTON[1] pulse of 3 clocks -> RReg_Button[1] and RReg_Event[1] stay 0.
REQ-036 SHALL check: Event_Clr[0] pulse with event set -> RReg_Event[0]=0, irq=0 next clock; Event_Clr coincident with new rising edge -> bit stays 1.
REQ-037 SHALL check: mode 01, WReg_LED=8'hA5 -> LED alternates 8'hA5 / 8'h00 every 3 clocks.
REQ-038 SHALL check: mode 11, WReg_Duty=64, WReg_LED=8'hFF -> LED=8'hFF for 64 of every 256 clocks; duty 0 -> LED constant 0.
REQ-039 SHALL check: rst_n asserted asynchronously between clock edges with SW=8'h3C debouncing -> all outputs 0 immediately; after release, RReg_Switch=8'h3C 6 clocks later, no event raised.
